reorder_buffer: RTL and testbench

In-order retirement buffer sitting directly downstream of the rename stage. It accepts one renamed instruction per cycle into a circular buffer and accepts out-of-order completion reports by ROB index. It retires at most one completed instruction per cycle from the head, returning the superseded physical register to the rename free list. A mispredicted branch reaching the head triggers a full flush and a one-cycle recovery pulse.

---
 rtl/rob_pkg.sv | 16 +
 rtl/reorder_buffer.sv | 141 ++++++++++++++
 tb/tb_reorder_buffer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: the per-entry record and the physical register
// index width, which has to track the rename stage's free list.
package rob_pkg;

  localparam int ROB_PREG_W = 6;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  is_branch;
    logic                  mispredict;
    logic                  rd_alloc;
    logic [ROB_PREG_W-1:0] old_p;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: one allocate, one out-of-order completion and one
// head commit per cycle; a mispredicted branch retiring at the head flushes everything.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int  ROB_DEPTH = 16,
  parameter int  PREG_W    = ROB_PREG_W,
  localparam int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  output logic [IDX_W-1:0]  alloc_tag_o,
  input  logic              alloc_rd_alloc_i,
  input  logic [PREG_W-1:0] alloc_rd_old_p_i,
  input  logic              alloc_is_branch_i,
  input  logic              cmpl_valid_i,
  input  logic [IDX_W-1:0]  cmpl_tag_i,
  input  logic              cmpl_mispredict_i,
  output logic              commit_free_valid_o,
  output logic [PREG_W-1:0] commit_free_preg_o,
  output logic              commit_valid_o,
  output logic [IDX_W-1:0]  commit_tag_o,
  output logic              recover_o,
  output logic              empty_o
);

  localparam logic [IDX_W-1:0] ONE_IDX    = IDX_W'(1);
  localparam logic [IDX_W:0]   ONE_CNT    = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W + 1)'(ROB_DEPTH);

  logic [IDX_W-1:0] head_reg, head_next;
  logic [IDX_W-1:0] tail_reg, tail_next;
  logic [IDX_W:0]   count_reg, count_next;

  rob_entry_t entry_q [ROB_DEPTH];
  rob_entry_t head_entry;

  logic commit_fire;
  logic flush;
  logic alloc_fire;
  logic cmpl_hit;

  assign head_entry  = entry_q[head_reg];
  assign commit_fire = head_entry.valid && head_entry.done;
  assign flush       = commit_fire && head_entry.mispredict;

  assign alloc_ready_o = (count_reg < FULL_COUNT) && !flush;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign alloc_tag_o   = tail_reg;
  assign empty_o       = (count_reg == '0);

  // Completions to slots that are not in flight (stale or flushed tags) are dropped.
  assign cmpl_hit = cmpl_valid_i && entry_q[cmpl_tag_i].valid;

  genvar gi;
  generate
    for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      localparam logic [IDX_W-1:0] ENTRY_IDX = IDX_W'(gi);

      rob_entry_t entry_reg;

      // Later statements win: the retire/flush clear overrides a same-cycle
      // completion, and an allocation rewrites the whole record.
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else begin
          if (cmpl_hit && (cmpl_tag_i == ENTRY_IDX)) begin
            entry_reg.done       <= 1'b1;
            entry_reg.mispredict <= cmpl_mispredict_i && entry_reg.is_branch;
          end
          if (flush || (commit_fire && (head_reg == ENTRY_IDX))) begin
            entry_reg.valid <= 1'b0;
          end
          if (alloc_fire && (tail_reg == ENTRY_IDX)) begin
            entry_reg <= '{
              valid:      1'b1,
              done:       1'b0,
              is_branch:  alloc_is_branch_i,
              mispredict: 1'b0,
              rd_alloc:   alloc_rd_alloc_i,
              old_p:      alloc_rd_old_p_i
            };
          end
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (alloc_fire) begin
      tail_next  = tail_reg + ONE_IDX;
      count_next = count_reg + ONE_CNT;
    end
    if (commit_fire) begin
      head_next  = head_reg + ONE_IDX;
      count_next = count_next - ONE_CNT;
    end
    // A flush restarts the buffer empty just past the retiring branch.
    if (flush) begin
      tail_next  = head_reg + ONE_IDX;
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid_o      <= 1'b0;
      commit_tag_o        <= '0;
      commit_free_valid_o <= 1'b0;
      commit_free_preg_o  <= '0;
      recover_o           <= 1'b0;
    end else begin
      commit_valid_o      <= commit_fire;
      commit_tag_o        <= commit_fire ? head_reg : '0;
      commit_free_valid_o <= commit_fire && head_entry.rd_alloc;
      commit_free_preg_o  <= (commit_fire && head_entry.rd_alloc) ? head_entry.old_p : '0;
      recover_o           <= flush;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a program-order queue model predicts every output each
// cycle; directed scenarios pin the model with literal values, then random traffic.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int PW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid_i;
  logic          alloc_ready_o;
  logic [IW-1:0] alloc_tag_o;
  logic          alloc_rd_alloc_i;
  logic [PW-1:0] alloc_rd_old_p_i;
  logic          alloc_is_branch_i;
  logic          cmpl_valid_i;
  logic [IW-1:0] cmpl_tag_i;
  logic          cmpl_mispredict_i;
  logic          commit_free_valid_o;
  logic [PW-1:0] commit_free_preg_o;
  logic          commit_valid_o;
  logic [IW-1:0] commit_tag_o;
  logic          recover_o;
  logic          empty_o;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_DEPTH(DEPTH), .PREG_W(PW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .alloc_valid_i       (alloc_valid_i),
    .alloc_ready_o       (alloc_ready_o),
    .alloc_tag_o         (alloc_tag_o),
    .alloc_rd_alloc_i    (alloc_rd_alloc_i),
    .alloc_rd_old_p_i    (alloc_rd_old_p_i),
    .alloc_is_branch_i   (alloc_is_branch_i),
    .cmpl_valid_i        (cmpl_valid_i),
    .cmpl_tag_i          (cmpl_tag_i),
    .cmpl_mispredict_i   (cmpl_mispredict_i),
    .commit_free_valid_o (commit_free_valid_o),
    .commit_free_preg_o  (commit_free_preg_o),
    .commit_valid_o      (commit_valid_o),
    .commit_tag_o        (commit_tag_o),
    .recover_o           (recover_o),
    .empty_o             (empty_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: in-flight instructions in program order, oldest first.
  typedef struct {
    int tag;
    bit done;
    bit br;
    bit mis;
    bit rd;
    int old;
  } ment_t;

  ment_t mq[$];
  int    next_tag;
  bit    e_cv, e_fv, e_rec;
  int    e_ct, e_fp;

  int free_log[$];
  int tag_log[$];
  int rec_cnt;
  int nofree_cnt;

  function automatic bit model_flush_now();
    return (mq.size() > 0) && mq[0].done && mq[0].mis;
  endfunction

  task automatic model_reset();
    mq.delete();
    next_tag = 0;
    e_cv = 0; e_ct = 0; e_fv = 0; e_fp = 0; e_rec = 0;
  endtask

  task automatic model_step(input bit r, input bit acc, input bit rd, input int oldp,
                            input bit br, input bit cv, input int ctag, input bit cmis);
    bit    commit, fl;
    int    h;
    ment_t ne;
    if (r) begin
      model_reset();
      return;
    end
    commit = (mq.size() > 0) && mq[0].done;
    fl     = commit && mq[0].mis;
    h      = commit ? mq[0].tag : 0;
    e_cv   = commit;
    e_ct   = h;
    e_fv   = commit && mq[0].rd;
    e_fp   = e_fv ? mq[0].old : 0;
    e_rec  = fl;
    if (cv) begin
      foreach (mq[i]) begin
        if (mq[i].tag == ctag) begin
          mq[i].done = 1;
          mq[i].mis  = cmis && mq[i].br;
        end
      end
    end
    if (commit) begin
      void'(mq.pop_front());
      if (fl) begin
        mq.delete();
        next_tag = (h + 1) % DEPTH;
      end
    end
    if (acc) begin
      ne.tag = next_tag; ne.done = 0; ne.br = br; ne.mis = 0; ne.rd = rd; ne.old = oldp;
      mq.push_back(ne);
      next_tag = (next_tag + 1) % DEPTH;
    end
  endtask

  task automatic compare_outputs(output bit e_ready);
    bit fl;
    fl      = model_flush_now();
    e_ready = (mq.size() < DEPTH) && !fl;
    chk("alloc_ready", alloc_ready_o, e_ready);
    chk("alloc_tag", alloc_tag_o, next_tag);
    chk("empty", empty_o, mq.size() == 0);
    chk("commit_valid", commit_valid_o, e_cv);
    if (e_cv) chk("commit_tag", commit_tag_o, e_ct);
    chk("free_valid", commit_free_valid_o, e_fv);
    if (e_fv) chk("free_preg", commit_free_preg_o, e_fp);
    chk("recover", recover_o, e_rec);
    if (commit_free_valid_o === 1'b1) free_log.push_back(int'(commit_free_preg_o));
    if (commit_valid_o === 1'b1) tag_log.push_back(int'(commit_tag_o));
    if (recover_o === 1'b1) rec_cnt++;
    if (commit_valid_o === 1'b1 && commit_free_valid_o === 1'b0) nofree_cnt++;
  endtask

  // One clock: drive, check on the falling edge, advance the model on the rising edge.
  task automatic cycle(input bit r, input bit av, input bit rd, input int oldp,
                       input bit br, input bit cv, input int ctag, input bit cmis);
    bit e_ready;
    rst               = r;
    alloc_valid_i     = av;
    alloc_rd_alloc_i  = rd;
    alloc_rd_old_p_i  = PW'(oldp);
    alloc_is_branch_i = br;
    cmpl_valid_i      = cv;
    cmpl_tag_i        = IW'(ctag);
    cmpl_mispredict_i = cmis;
    @(negedge clk);
    compare_outputs(e_ready);
    @(posedge clk);
    model_step(r, av && e_ready, rd, oldp, br, cv, ctag, cmis);
    #1;
  endtask

  task automatic do_alloc(input bit rd, input int oldp, input bit br);
    cycle(0, 1, rd, oldp, br, 0, 0, 0);
  endtask

  task automatic do_cmpl(input int tag, input bit mis);
    cycle(0, 0, 0, 0, 0, 1, tag, mis);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    free_log.delete();
    tag_log.delete();
    rec_cnt    = 0;
    nofree_cnt = 0;
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    rst = 1; alloc_valid_i = 0; alloc_rd_alloc_i = 0; alloc_rd_old_p_i = '0;
    alloc_is_branch_i = 0; cmpl_valid_i = 0; cmpl_tag_i = '0; cmpl_mispredict_i = 0;
    model_reset();
    rec_cnt = 0; nofree_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    chk("rst_ready", alloc_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_tag", alloc_tag_o, 0);
    chk("rst_cv", commit_valid_o, 0);
    chk("rst_fv", commit_free_valid_o, 0);
    chk("rst_rec", recover_o, 0);

    // In-order retirement of out-of-order completions.
    do_reset();
    do_alloc(1, 33, 0);
    do_alloc(1, 34, 0);
    do_alloc(1, 35, 0);
    do_cmpl(2, 0);
    do_cmpl(0, 0);
    do_cmpl(1, 0);
    do_idle(4);
    chk("s1_nfree", free_log.size(), 3);
    chk("s1_free0", at(free_log, 0), 33);
    chk("s1_free1", at(free_log, 1), 34);
    chk("s1_free2", at(free_log, 2), 35);
    chk("s1_tag2", at(tag_log, 2), 2);
    chk("s1_empty", empty_o, 1);

    // Full buffer, refused 17th allocation, wrap after one commit.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_alloc(1, 10 + i, 0);
    chk("s2_full_ready", alloc_ready_o, 0);
    do_alloc(1, 60, 0);
    do_cmpl(0, 0);
    chk("s2_still_full", alloc_ready_o, 0);
    do_idle(1);
    chk("s2_ready_after", alloc_ready_o, 1);
    chk("s2_wrap_tag", alloc_tag_o, 0);
    do_alloc(1, 61, 0);
    chk("s2_free0", at(free_log, 0), 10);

    // Mispredicted branch at tag 3 flushes younger 4..6.
    do_reset();
    for (int i = 0; i < 7; i++) do_alloc(1, 20 + i, (i == 3));
    do_cmpl(4, 0);
    do_cmpl(5, 0);
    do_cmpl(6, 0);
    do_cmpl(0, 0);
    do_cmpl(1, 0);
    do_cmpl(2, 0);
    do_idle(3);
    do_cmpl(3, 1);
    do_idle(3);
    chk("s3_ncommit", tag_log.size(), 4);
    chk("s3_last_tag", at(tag_log, 3), 3);
    chk("s3_recover", rec_cnt, 1);
    chk("s3_empty", empty_o, 1);
    chk("s3_next_tag", alloc_tag_o, 4);

    // Retire without a destination register.
    do_reset();
    do_alloc(0, 7, 0);
    do_cmpl(0, 0);
    do_idle(2);
    chk("s4_nofree", nofree_cnt, 1);
    chk("s4_nfree", free_log.size(), 0);

    // Stale completion and mispredict flag on a non-branch.
    do_reset();
    do_alloc(1, 40, 0);
    do_alloc(1, 41, 0);
    do_cmpl(9, 1);
    do_cmpl(0, 1);
    do_idle(3);
    chk("s5_recover", rec_cnt, 0);
    chk("s5_ncommit", tag_log.size(), 1);
    chk("s5_empty", empty_o, 0);
    chk("s5_tag", alloc_tag_o, 2);
    do_cmpl(1, 0);
    do_idle(2);

    // Reset with five entries in flight and a commit pending.
    do_reset();
    for (int i = 0; i < 5; i++) do_alloc(1, 50 + i, 0);
    do_cmpl(0, 0);
    cycle(1, 1, 1, 63, 0, 1, 1, 0);
    chk("s6_empty", empty_o, 1);
    chk("s6_tag", alloc_tag_o, 0);
    chk("s6_cv", commit_valid_o, 0);
    chk("s6_ct", commit_tag_o, 0);
    chk("s6_fv", commit_free_valid_o, 0);
    chk("s6_fp", commit_free_preg_o, 0);
    chk("s6_rec", recover_o, 0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r, av, rd, br, cv, cmis;
      int ctag;
      r    = ($urandom_range(0, 499) == 0);
      av   = ($urandom_range(0, 9) < 7);
      rd   = ($urandom_range(0, 3) != 0);
      br   = ($urandom_range(0, 4) == 0);
      cv   = ($urandom_range(0, 9) < 6);
      cmis = ($urandom_range(0, 9) == 0);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8)
        ctag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        ctag = $urandom_range(0, DEPTH - 1);
      cycle(r, av, rd, $urandom_range(0, 63), br, cv, ctag, cmis);
    end
    do_idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
